// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, parity encoding and frame-format helpers.
// Used by the transmit framer and intended for the matching receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_e;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    localparam int DATA_LEN_BASE = 5;
    localparam int STOP_BITS_MAX = 2;

    // data_len field 00..11 selects 5..8 data bits
    function automatic logic [3:0] data_bits(input logic [1:0] len);
        return 4'(len) + 4'(DATA_LEN_BASE);
    endfunction

    // Encoding 11 is reserved and behaves as no parity
    function automatic parity_e to_parity(input logic [1:0] mode);
        case (mode)
            2'b01:   return PAR_EVEN;
            2'b10:   return PAR_ODD;
            default: return PAR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_framer_if.sv
// Ready/valid byte handshake between the UART register/FIFO side and the transmitter.
interface uart_tx_framer_if #(
    parameter int DATA_W = 8
) ();
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_ready;

    modport master (output tx_valid, output tx_data, input tx_ready);
    modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-time generator: a down-counter reloaded with div-1 on load and at each tick.
// A divisor of 0 behaves as 1, giving a tick every clock.
module uart_baud_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [DIV_W-1:0] div,
    input  logic             load,
    output logic             tick
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    logic [DIV_W-1:0] count_q;
    logic [DIV_W-1:0] reload;

    assign reload = (div == '0) ? '0 : div - ONE;
    assign tick   = (count_q == '0);

    always_ff @(posedge clock) begin
        if (reset)
            count_q <= '0;
        else if (load || tick)
            count_q <= reload;
        else
            count_q <= count_q - ONE;
    end

endmodule

// File: rtl/uart_tx_framer.sv
// Run-time configurable UART transmitter (5-8 data bits, none/even/odd parity, 1-2 stops).
// Define UART_TX_BREAK_EN to add the break_req input and the BREAK line state.
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [DIV_W-1:0] baud_div,
    input  logic [1:0]       data_len,
    input  logic [1:0]       parity_mode,
    input  logic             stop2,
`ifdef UART_TX_BREAK_EN
    input  logic             break_req,
`endif
    uart_tx_framer_if.slave  tx_if,
    output logic             tx_out,
    output logic             tx_busy,
    output logic             frame_done
);

    state_e            state_q, state_n;
    logic [DATA_W-1:0] shift_q, shift_n;
    logic [3:0]        bit_cnt_q, bit_cnt_n;
    logic              done_q, done_n;
    logic              launch;
    logic              tick;
    logic              tx_ready_c;
    logic [DIV_W-1:0]  div_sel;

    logic [3:0]        n_bits_q;
    logic              par_en_q;
    logic              par_bit_q;
    logic [1:0]        stop_bits_q;
    logic [DIV_W-1:0]  div_q;

    logic [DATA_W-1:0] data_mask;
    logic              par_bit_in;
    parity_e           par_in;

    // While idle the divisor input is live so the first bit is timed correctly
    assign div_sel = (state_q == IDLE) ? baud_div : div_q;

    uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
        .clock (clock),
        .reset (reset),
        .div   (div_sel),
        .load  (launch),
        .tick  (tick)
    );

    always_comb begin
        data_mask = '0;
        for (int i = 0; i < DATA_W; i++)
            data_mask[i] = (i < int'(data_bits(data_len)));
    end

    assign par_in     = to_parity(parity_mode);
    assign par_bit_in = (^(tx_if.tx_data & data_mask)) ^ (par_in == PAR_ODD);

    always_ff @(posedge clock) begin
        if (reset) begin
            n_bits_q    <= '0;
            par_en_q    <= 1'b0;
            par_bit_q   <= 1'b0;
            stop_bits_q <= '0;
            div_q       <= '0;
        end else if (launch) begin
            n_bits_q    <= data_bits(data_len);
            par_en_q    <= (par_in != PAR_NONE);
            par_bit_q   <= par_bit_in;
            stop_bits_q <= stop2 ? 2'(STOP_BITS_MAX) : 2'd1;
            div_q       <= baud_div;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_n;
            shift_q   <= shift_n;
            bit_cnt_q <= bit_cnt_n;
            done_q    <= done_n;
        end
    end

`ifdef UART_TX_BREAK_EN
    // Index of the last bit of a full frame: 1+N+P+S bits counted from 0
    logic [3:0] frame_last;
    assign frame_last = n_bits_q + {3'b000, par_en_q} + {2'b00, stop_bits_q};
`endif

    always_comb begin
        state_n    = state_q;
        shift_n    = shift_q;
        bit_cnt_n  = bit_cnt_q;
        done_n     = 1'b0;
        launch     = 1'b0;
        tx_ready_c = 1'b0;
        tx_out     = 1'b1;
        case (state_q)
            IDLE: begin
                tx_ready_c = 1'b1;
`ifdef UART_TX_BREAK_EN
                if (break_req) begin
                    tx_ready_c = 1'b0;
                    state_n    = BREAK;
                    bit_cnt_n  = '0;
                    launch     = 1'b1;
                end else
`endif
                if (tx_if.tx_valid) begin
                    state_n   = START;
                    shift_n   = tx_if.tx_data;
                    bit_cnt_n = '0;
                    launch    = 1'b1;
                end
            end
            START: begin
                tx_out = 1'b0;
                if (tick) begin
                    state_n   = DATA;
                    bit_cnt_n = '0;
                end
            end
            DATA: begin
                tx_out = shift_q[0];
                if (tick) begin
                    shift_n = shift_q >> 1;
                    if (bit_cnt_q == n_bits_q - 4'd1) begin
                        bit_cnt_n = '0;
                        state_n   = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_n = bit_cnt_q + 4'd1;
                    end
                end
            end
            PARITY: begin
                tx_out = par_bit_q;
                if (tick) begin
                    state_n   = STOP;
                    bit_cnt_n = '0;
                end
            end
            STOP: begin
                if (tick) begin
                    if (bit_cnt_q == 4'(stop_bits_q) - 4'd1) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        bit_cnt_n = bit_cnt_q + 4'd1;
                    end
                end
            end
`ifdef UART_TX_BREAK_EN
            // Line held low for a full frame, extended while the request persists
            BREAK: begin
                tx_out = 1'b0;
                if (tick) begin
                    if (bit_cnt_q == frame_last) begin
                        if (!break_req) begin
                            state_n   = STOP;
                            bit_cnt_n = '0;
                        end
                    end else begin
                        bit_cnt_n = bit_cnt_q + 4'd1;
                    end
                end
            end
`endif
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign tx_if.tx_ready = tx_ready_c;
    assign tx_busy        = !tx_ready_c;
    assign frame_done     = done_q;

endmodule
